// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU among NUM_REQ requesters.
// One transaction in flight; a missing ALU ack completes with an error response.
module alu_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        s_valid,
    output logic [NUM_REQ-1:0]        s_ready,
    input  logic [2*NUM_REQ-1:0]      s_op,
    input  logic [DATA_W*NUM_REQ-1:0] s_a,
    input  logic [DATA_W*NUM_REQ-1:0] s_b,
    output logic [NUM_REQ-1:0]        r_valid,
    input  logic [NUM_REQ-1:0]        r_ready,
    output logic [DATA_W-1:0]         r_data,
    output logic                      r_err,
    output logic                      alu_req,
    output logic [1:0]                alu_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    input  logic                      alu_ack,
    input  logic [DATA_W-1:0]         alu_y
);

    localparam int unsigned NR = NUM_REQ;
    localparam int          PW = $clog2(NUM_REQ);
    localparam int          CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       ptr, id_q, winner;
    logic                found;
    int unsigned         scan_idx;
    logic [1:0]          sel_op, op_q;
    logic [DATA_W-1:0]   sel_a, sel_b, a_q, b_q, result_q;
    logic                err_q;
    logic [CW-1:0]       cnt;
    logic                grant, ack_hit, timeout_hit, resp_done;

    // Round-robin search starting at ptr; also muxes the winner's operands.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        sel_op   = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            scan_idx = 32'(ptr) + i;
            if (scan_idx >= NR)
                scan_idx = scan_idx - NR;
            if (!found && s_valid[PW'(scan_idx)]) begin
                found  = 1'b1;
                winner = PW'(scan_idx);
                sel_op = s_op[2*scan_idx +: 2];
                sel_a  = s_a[DATA_W*scan_idx +: DATA_W];
                sel_b  = s_b[DATA_W*scan_idx +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and handshake outputs; s_ready is held low while reset is asserted.
    always_comb begin
        state_nxt   = state;
        s_ready     = '0;
        r_valid     = '0;
        alu_req     = 1'b0;
        grant       = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        resp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (found && rst_n) begin
                    s_ready[winner] = 1'b1;
                    grant           = 1'b1;
                    state_nxt       = ISSUE;
                end
            end
            ISSUE: begin
                alu_req   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (alu_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                r_valid[id_q] = 1'b1;
                if (r_ready[id_q]) begin
                    resp_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latched request, response, timeout counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            id_q     <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            if (grant) begin
                id_q <= winner;
                op_q <= sel_op;
                a_q  <= sel_a;
                b_q  <= sel_b;
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT && !alu_ack)
                cnt <= cnt + CW'(1);
            if (ack_hit) begin
                result_q <= alu_y;
                err_q    <= 1'b0;
            end else if (timeout_hit) begin
                result_q <= '0;
                err_q    <= 1'b1;
            end
            if (resp_done)
                ptr <= (id_q == PW'(NR - 1)) ? '0 : id_q + PW'(1);
        end
    end

    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign r_data = result_q;
    assign r_err  = err_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: scenario tasks plus randomized traffic
// checked against a round-robin / arithmetic reference model.
module tb_alu_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     s_valid, s_ready, r_valid, r_ready;
    logic [2*NR-1:0]   s_op;
    logic [DW*NR-1:0]  s_a, s_b;
    logic [DW-1:0]     r_data, alu_a, alu_b, alu_y;
    logic              r_err, alu_req, alu_ack;
    logic [1:0]        alu_op;
    bit                ack_en;

    int vec = 0;
    int mis = 0;
    int mptr;

    // observations from run_one
    int          o_gid, o_pulses, o_lat, o_rid;
    logic [1:0]  o_op;
    logic [DW-1:0] o_a, o_b, o_d;
    logic [NR-1:0] o_rv;
    logic        o_e;

    alu_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_a(s_a), .s_b(s_b),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err),
        .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ack(alu_ack), .alu_y(alu_y)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int unsigned r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) + 256 - int'(b);
            2'd2:    r = int'(a ^ b);
            default: r = int'(a & b);
        endcase
        return DW'(r % 256);
    endfunction

    // ALU responder: ack one cycle after req; garbage on alu_y otherwise.
    always @(posedge clk) begin
        alu_ack <= alu_req && ack_en;
        alu_y   <= (alu_req && ack_en) ? ref_alu(alu_op, alu_a, alu_b) : DW'($urandom);
    end

    function automatic int exp_winner(input logic [NR-1:0] m);
        for (int i = 0; i < NR; i++)
            if (m[(mptr + i) % NR]) return (mptr + i) % NR;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int idx = -1;
        int n = 0;
        for (int i = 0; i < NR; i++)
            if (v[i]) begin idx = i; n++; end
        return (n == 1) ? idx : -1;
    endfunction

    task automatic set_req(input int i, input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        s_op[2*i +: 2]  = op;
        s_a[DW*i +: DW] = a;
        s_b[DW*i +: DW] = b;
    endtask

    // Waits for a grant, optionally drops that s_valid, and follows the transaction
    // until r_valid; returns at the first RESP cycle (sampled after negedge).
    task automatic run_one(input bit drop);
        bit got = 0;
        bit done = 0;
        o_gid = -1; o_pulses = 0; o_lat = -1; o_rid = -1;
        o_op = '0; o_a = '0; o_b = '0; o_d = '0; o_rv = '0; o_e = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (s_ready != '0) begin
                got = 1;
                o_gid = onehot_idx(s_ready);
            end
        end
        if (!got) return;
        @(posedge clk); #1;
        if (drop && o_gid >= 0) s_valid = s_valid & ~(4'b0001 << o_gid);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk); #1;
            if (alu_req) begin o_pulses++; o_op = alu_op; o_a = alu_a; o_b = alu_b; end
            if (r_valid != '0) begin
                done = 1; o_lat = c; o_rv = r_valid; o_d = r_data; o_e = r_err;
                o_rid = onehot_idx(r_valid);
            end
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mptr = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s_valid = '0; r_ready = '0; s_op = '0; s_a = '0; s_b = '0; ack_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vec++; if (s_ready !== 4'b0) begin mis++; $display("FAIL reset_s_ready: got %b exp 0000", s_ready); end
        vec++; if (r_valid !== 4'b0) begin mis++; $display("FAIL reset_r_valid: got %b exp 0000", r_valid); end
        vec++; if (r_data !== 8'h00) begin mis++; $display("FAIL reset_r_data: got %h exp 00", r_data); end
        vec++; if (r_err !== 1'b0) begin mis++; $display("FAIL reset_r_err: got %b exp 0", r_err); end
        vec++; if (alu_req !== 1'b0) begin mis++; $display("FAIL reset_alu_req: got %b exp 0", alu_req); end
        vec++; if (alu_op !== 2'b0) begin mis++; $display("FAIL reset_alu_op: got %b exp 00", alu_op); end
        vec++; if (alu_a !== 8'h00) begin mis++; $display("FAIL reset_alu_a: got %h exp 00", alu_a); end
        vec++; if (alu_b !== 8'h00) begin mis++; $display("FAIL reset_alu_b: got %h exp 00", alu_b); end
        rst_n = 1'b1;
        mptr = 0;
    endtask

    task automatic test_basic;
        @(negedge clk);
        set_req(0, 2'd0, 8'd200, 8'd100);
        r_ready = '1;
        s_valid = 4'b0001;
        run_one(1);
        vec++; if (o_gid !== 0) begin mis++; $display("FAIL basic_gid: got %0d exp 0", o_gid); end
        vec++; if (o_pulses !== 1) begin mis++; $display("FAIL basic_req_pulses: got %0d exp 1", o_pulses); end
        vec++; if ({o_op, o_a, o_b} !== {2'd0, 8'd200, 8'd100}) begin mis++; $display("FAIL basic_alu_bus: got op=%0d a=%0d b=%0d exp 0/200/100", o_op, o_a, o_b); end
        vec++; if (o_lat !== 3) begin mis++; $display("FAIL basic_latency: got %0d exp 3", o_lat); end
        vec++; if (o_rv !== 4'b0001) begin mis++; $display("FAIL basic_r_valid: got %b exp 0001", o_rv); end
        vec++; if ({o_e, o_d} !== {1'b0, 8'd44}) begin mis++; $display("FAIL basic_r_data: got err=%b data=%0d exp 0/44", o_e, o_d); end
        mptr = 1;
        @(negedge clk); #1;
        vec++; if (r_valid !== 4'b0) begin mis++; $display("FAIL basic_r_valid_drop: got %b exp 0000", r_valid); end
    endtask

    task automatic test_ops;
        logic [1:0]    ops [3] = '{2'd1, 2'd2, 2'd3};
        logic [DW-1:0] as  [3] = '{8'd5, 8'hF0, 8'hF0};
        logic [DW-1:0] bs  [3] = '{8'd10, 8'h3C, 8'h3C};
        logic [DW-1:0] exs [3] = '{8'd251, 8'hCC, 8'h30};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            set_req(2, ops[t], as[t], bs[t]);
            s_valid = 4'b0100;
            run_one(1);
            vec++; if (o_gid !== 2) begin mis++; $display("FAIL ops%0d_gid: got %0d exp 2", t, o_gid); end
            vec++; if (o_rv !== 4'b0100) begin mis++; $display("FAIL ops%0d_r_valid: got %b exp 0100", t, o_rv); end
            vec++; if ({o_e, o_d} !== {1'b0, exs[t]}) begin mis++; $display("FAIL ops%0d_r_data: got err=%b data=%h exp 0/%h", t, o_e, o_d, exs[t]); end
            mptr = 3;
        end
    endtask

    task automatic test_back_to_back;
        int eg;
        logic [DW-1:0] ed;
        do_reset();
        @(negedge clk);
        r_ready = '1;
        for (int i = 0; i < NR; i++) set_req(i, 2'($urandom), DW'($urandom), DW'($urandom));
        s_valid = 4'b1111;
        for (int t = 0; t < 6; t++) begin
            eg = exp_winner(s_valid);
            ed = ref_alu(s_op[2*eg +: 2], s_a[DW*eg +: DW], s_b[DW*eg +: DW]);
            run_one(0);
            vec++; if (o_gid !== eg) begin mis++; $display("FAIL b2b%0d_gid: got %0d exp %0d", t, o_gid, eg); end
            vec++; if (o_lat !== 3) begin mis++; $display("FAIL b2b%0d_latency: got %0d exp 3", t, o_lat); end
            vec++; if (o_rv !== (4'b0001 << eg)) begin mis++; $display("FAIL b2b%0d_r_valid: got %b exp idx %0d", t, o_rv, eg); end
            vec++; if (o_d !== ed) begin mis++; $display("FAIL b2b%0d_r_data: got %h exp %h", t, o_d, ed); end
            mptr = (eg + 1) % NR;
            for (int i = 0; i < NR; i++) set_req(i, 2'($urandom), DW'($urandom), DW'($urandom));
            if (t == 5) s_valid = '0;
        end
    endtask

    task automatic test_resp_hold;
        int eg;
        logic [DW-1:0] d0;
        @(negedge clk);
        set_req(1, 2'($urandom), DW'($urandom), DW'($urandom));
        r_ready = 4'b1101;
        s_valid = 4'b0010;
        eg = exp_winner(s_valid);
        run_one(1);
        d0 = ref_alu(s_op[3:2], s_a[15:8], s_b[15:8]);
        vec++; if (o_gid !== eg || o_d !== d0) begin mis++; $display("FAIL hold_first: got gid=%0d data=%h exp %0d/%h", o_gid, o_d, eg, d0); end
        mptr = 2;
        s_valid = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            vec++;
            if (r_valid !== 4'b0010 || r_data !== d0 || s_ready !== 4'b0) begin
                mis++; $display("FAIL hold_cycle%0d: got rv=%b data=%h sr=%b exp 0010/%h/0000", c, r_valid, r_data, s_ready, d0);
            end
        end
        @(negedge clk);
        r_ready = '1;
        eg = exp_winner(s_valid);
        run_one(1);
        s_valid = '0;
        vec++; if (o_gid !== eg) begin mis++; $display("FAIL hold_next_gid: got %0d exp %0d", o_gid, eg); end
        mptr = (eg + 1) % NR;
    endtask

    task automatic test_timeout;
        int eg;
        logic [DW-1:0] ed;
        @(negedge clk);
        ack_en = 1'b0;
        r_ready = '1;
        set_req(0, 2'($urandom), DW'($urandom), DW'($urandom));
        s_valid = 4'b0001;
        run_one(1);
        vec++; if (o_pulses !== 1) begin mis++; $display("FAIL to_req_pulses: got %0d exp 1", o_pulses); end
        vec++; if (o_lat !== TO + 2) begin mis++; $display("FAIL to_latency: got %0d exp %0d", o_lat, TO + 2); end
        vec++; if ({o_e, o_d} !== {1'b1, 8'h00}) begin mis++; $display("FAIL to_err: got err=%b data=%h exp 1/00", o_e, o_d); end
        mptr = 1;
        @(negedge clk);
        ack_en = 1'b1;
        set_req(3, 2'($urandom), DW'($urandom), DW'($urandom));
        s_valid = 4'b1000;
        eg = exp_winner(s_valid);
        ed = ref_alu(s_op[7:6], s_a[31:24], s_b[31:24]);
        run_one(1);
        vec++; if (o_gid !== eg || o_lat !== 3) begin mis++; $display("FAIL to_recover: got gid=%0d lat=%0d exp %0d/3", o_gid, o_lat, eg); end
        vec++; if ({o_e, o_d} !== {1'b0, ed}) begin mis++; $display("FAIL to_recover_data: got err=%b data=%h exp 0/%h", o_e, o_d, ed); end
        mptr = (eg + 1) % NR;
    endtask

    task automatic test_reset_mid;
        bit got = 0;
        bit seen3 = 0;
        @(negedge clk);
        r_ready = '1;
        set_req(3, 2'd2, 8'hA5, 8'h5A);
        s_valid = 4'b1000;
        for (int c = 0; c < 40 && !got; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (s_ready == 4'b1000) got = 1;
        end
        vec++; if (!got) begin mis++; $display("FAIL rstmid_grant: got none exp idx 3"); end
        @(posedge clk); #1;
        s_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec++;
        if ({s_ready, r_valid, r_data, r_err, alu_req, alu_op, alu_a, alu_b} !== '0) begin
            mis++; $display("FAIL rstmid_outputs: got sr=%b rv=%b d=%h e=%b req=%b op=%b a=%h b=%h exp all 0",
                            s_ready, r_valid, r_data, r_err, alu_req, alu_op, alu_a, alu_b);
        end
        repeat (2) begin @(negedge clk); #1; if (r_valid[3]) seen3 = 1; end
        rst_n = 1'b1;
        mptr = 0;
        repeat (3) begin @(negedge clk); #1; if (r_valid[3]) seen3 = 1; end
        vec++; if (seen3) begin mis++; $display("FAIL rstmid_no_resp: got r_valid[3]=1 exp 0"); end
        @(negedge clk);
        set_req(1, 2'd0, 8'd1, 8'd2);
        set_req(3, 2'd0, 8'd3, 8'd4);
        s_valid = 4'b1010;
        run_one(1);
        s_valid = '0;
        vec++; if (o_gid !== 1 || o_rv !== 4'b0010 || o_d !== 8'd3) begin
            mis++; $display("FAIL rstmid_after: got gid=%0d rv=%b data=%0d exp 1/0010/3", o_gid, o_rv, o_d);
        end
        mptr = 2;
    endtask

    task automatic test_random;
        int eg, k;
        bit ae;
        logic [1:0] eop;
        logic [DW-1:0] ea, eb, ed;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) set_req(i, 2'($urandom), DW'($urandom), DW'($urandom));
            s_valid = s_valid | 4'($urandom);
            if (s_valid == '0) s_valid = 4'b0001 << $urandom_range(3, 0);
            r_ready = 4'($urandom);
            ae = ($urandom_range(7, 0) != 0);
            ack_en = ae;
            eg = exp_winner(s_valid);
            eop = s_op[2*eg +: 2]; ea = s_a[DW*eg +: DW]; eb = s_b[DW*eg +: DW];
            ed = ae ? ref_alu(eop, ea, eb) : 8'h00;
            run_one(1);
            if (t == 39) s_valid = '0;
            vec++; if (o_gid !== eg) begin mis++; $display("FAIL rnd%0d_gid: got %0d exp %0d", t, o_gid, eg); end
            vec++; if ({o_op, o_a, o_b} !== {eop, ea, eb} || o_pulses !== 1) begin
                mis++; $display("FAIL rnd%0d_alu_bus: got %0d/%h/%h x%0d exp %0d/%h/%h x1", t, o_op, o_a, o_b, o_pulses, eop, ea, eb);
            end
            vec++; if (o_lat !== (ae ? 3 : TO + 2)) begin mis++; $display("FAIL rnd%0d_latency: got %0d exp %0d", t, o_lat, ae ? 3 : TO + 2); end
            vec++; if (o_rv !== (4'b0001 << eg) || {o_e, o_d} !== {!ae, ed}) begin
                mis++; $display("FAIL rnd%0d_resp: got rv=%b err=%b data=%h exp idx %0d err=%b data=%h", t, o_rv, o_e, o_d, eg, !ae, ed);
            end
            if (o_rid >= 0 && !r_ready[o_rid]) begin
                k = $urandom_range(3, 0);
                repeat (k) begin
                    @(negedge clk); #1;
                    vec++;
                    if (r_valid !== (4'b0001 << o_rid) || r_data !== o_d || s_ready !== '0) begin
                        mis++; $display("FAIL rnd%0d_hold: got rv=%b data=%h sr=%b", t, r_valid, r_data, s_ready);
                    end
                end
                @(negedge clk);
                r_ready = '1;
            end
            mptr = (eg + 1) % NR;
        end
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ops();
        test_back_to_back();
        test_resp_hold();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one single-cycle-latency ALU (req/ack handshake; 2-bit op; DATA_W operands/result) among NUM_REQ requesters.
- Round-robin arbitration with one transaction in flight at a time.
- Per-requester valid/ready request and response handshakes; ack-timeout error reporting.
- Sits between client blocks and the ALU; owns the ALU's req/op/a/b inputs exclusively.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 8, operand/result width.
- TIMEOUT_CYC, 8, max WAIT cycles without ALU ack before error completion (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  NUM_REQ  per-requester request valid
- s_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
- s_op  in  2*NUM_REQ  packed ops, requester i at [2i+1:2i]; 0 add, 1 sub, 2 xor, 3 and
- s_a  in  DATA_W*NUM_REQ  packed operand a
- s_b  in  DATA_W*NUM_REQ  packed operand b
- r_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
- r_ready  in  NUM_REQ  per-requester response accept
- r_data  out  DATA_W  shared response result
- r_err  out  1  response is a timeout error
- alu_req  out  1  ALU request
- alu_op  out  2  ALU op
- alu_a  out  DATA_W  ALU operand a
- alu_b  out  DATA_W  ALU operand b
- alu_ack  in  1  ALU ack (one cycle after alu_req)
- alu_y  in  DATA_W  ALU result, valid while alu_ack=1

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr pointer=0.
  - All outputs 0: s_ready, r_valid, r_data, r_err, alu_req, alu_op, alu_a, alu_b.
  - Latched op/a/b/id/result/timeout counter cleared.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any s_valid: winner = first asserted index searching ptr, ptr+1, ... mod NUM_REQ.
  - s_ready[winner]=1 combinationally this cycle; latch op/a/b/id at the clock edge; go ISSUE.
  - If no s_valid: stay; s_ready=0.
- ISSUE: alu_req=1 for exactly one cycle; alu_op/a/b = latched values; go WAIT; clear timeout counter.
- WAIT:
  - alu_req=0.
  - alu_ack=1: capture alu_y into result, err=0, go RESP.
  - Otherwise increment counter; at count TIMEOUT_CYC: result=0, err=1, go RESP.
- RESP:
  - r_valid[id]=1; r_data=result, r_err=err, both held stable.
  - On r_ready[id]=1: drop r_valid, ptr=(id+1) mod NUM_REQ, go IDLE.
  - r_ready of other indices ignored.
- alu_op/alu_a/alu_b hold the latched values in every state after the first grant; change only on a new grant.
- Nominal latency: accept cycle T, alu_req at T+1, ack at T+2, r_valid at T+3. Min 4 cycles per transaction.
- alu_ack in IDLE/ISSUE/RESP: ignored.
- s_valid dropping before grant: legal, no effect. Requesters not granted wait; s_ready never asserted outside IDLE.
- Result arithmetic is the ALU's (mod 2^DATA_W); the arbiter passes alu_y unmodified.
- Reset mid-transaction: transaction discarded, no response, ptr=0.
- Fairness: a continuously requesting client is granted within NUM_REQ transactions.

Test Plan:
- Req0 only, op=0, a=200, b=100, r_ready=1 -> s_ready[0] at T; alu_req=1 at T+1 with op=0/200/100; r_valid[0]=1 at T+3, r_data=44, r_err=0.
- Req2, op=1, a=5, b=10 -> r_valid[2], r_data=251. Then op=2, a=0xF0, b=0x3C -> 0xCC. Then op=3 -> 0x30.
- All 4 s_valid held high, r_ready all 1 -> grant order 0,1,2,3,0,1; each r_valid goes to the matching index only.
- r_ready[1] low for 5 cycles during RESP -> r_valid[1]/r_data stable 5 cycles; s_ready all 0; next grant only after the handshake.
- alu_ack tied 0 -> alu_req pulses once; r_valid after TIMEOUT_CYC=8 WAIT cycles with r_err=1, r_data=0; next transaction with ack restored completes normally.
- rst_n pulsed low during WAIT for req3 -> all outputs 0 immediately, no r_valid[3]; after release with req1 and req3 valid -> req1 granted first (ptr=0).
